coin_credit_fsm: RTL and testbench
==================================

Name: coin_credit_fsm

Overview:
Upstream stage of the vending-machine display path. It accepts coin and button inputs, keeps the customer credit in 5-cent units (0..12 = 0..60 cents), vends against a fixed price and pays out change one nickel at a time. Its registered credit[3:0] drives the 4-bit nickel-count input (a3..a0) of the ones-digit decoder and the tens-digit decoder.

Parameters:
MAX_CREDIT, 12, maximum credit in nickels (60 cents); must be 1..15
PRICE, 7, item price in nickels (35 cents); must be 1..MAX_CREDIT

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
coin_nickel  in  1  5-cent coin level, already synchronised to clk
coin_dime  in  1  10-cent coin level, already synchronised
coin_quarter  in  1  25-cent coin level, already synchronised
vend_req  in  1  purchase button level, already synchronised
cancel  in  1  refund button level, already synchronised
credit  out  4  current credit in nickels; feeds a3..a0 of the digit decoders
dispense  out  1  one-cycle pulse: item released
change_nickel  out  1  one-cycle pulse per nickel returned
coin_reject  out  1  one-cycle pulse: coin returned unaccepted
vend_denied  out  1  one-cycle pulse: vend_req with insufficient credit
busy  out  1  high in VEND and CHANGE states

Behaviour:
- Reset (rst_n low, asynchronous): credit=0, state=ACCEPT, dispense, change_nickel, coin_reject and vend_denied all 0, busy=0. All five input-history registers reset to 1, so a level already held high through reset does not produce an edge until released and re-pressed.
- Edge detect: event = input & ~previous-sample, evaluated every cycle in every state. Each press counts exactly once.
- All outputs are registered. The effect of an edge sampled at clock edge N is visible after edge N.
- Coin values: nickel=1, dime=2, quarter=5.
- State ACCEPT, evaluated in this priority order:
  1. cancel edge: if credit>0, go to CHANGE; otherwise no action. Any coin edge in the same cycle is rejected.
  2. vend_req edge with credit>=PRICE: credit <= credit-PRICE, dispense=1, go to VEND. A coin edge in the same cycle is rejected.
  3. vend_req edge with credit<PRICE: vend_denied=1 and stay in ACCEPT. A coin edge in the same cycle is still processed normally.
  4. Exactly one coin edge: if credit+value<=MAX_CREDIT, add it to credit; otherwise coin_reject=1 and credit is unchanged (no partial acceptance).
  5. Two or more coin edges in the same cycle: all are rejected, coin_reject=1 for one cycle, credit unchanged.
- State VEND (one cycle, busy=1): dispense returns to 0. Go to CHANGE if credit>0, else to ACCEPT.
- State CHANGE (busy=1): each cycle credit <= credit-1 and change_nickel=1. When credit would reach 0, the final pulse is issued and the next state is ACCEPT. An N-nickel refund therefore gives exactly N consecutive pulses.
- In VEND or CHANGE:
  - Any coin edge gives coin_reject=1 and no credit change.
  - vend_req and cancel edges are ignored. No vend_denied is raised.
- Arithmetic: the sum uses 5-bit internal width, compared against MAX_CREDIT before commit. credit never exceeds MAX_CREDIT and never underflows below 0.
- Reset asserted mid-VEND or mid-CHANGE aborts immediately to the reset values. Pending change is forfeited.

Test Plan:
- Reset, then quarter, dime, nickel (one edge each, separated by idle cycles) -> credit goes 5, 7, 8. No reject, vend_denied, dispense or change pulses.
- With credit=8 and PRICE=7, vend_req edge -> credit=1 with dispense for 1 cycle, then busy state, then one change_nickel pulse, then credit=0 and back in ACCEPT with busy=0.
- With credit=10, quarter edge -> coin_reject for 1 cycle and credit stays 10. A following dime edge -> credit=12. A further nickel edge -> coin_reject.
- With credit=3, vend_req -> vend_denied for 1 cycle and credit stays 3. Then cancel -> exactly 3 consecutive change_nickel pulses, credit counts 2, 1, 0, then ACCEPT.
- Nickel and dime rising in the same cycle -> single coin_reject pulse, credit unchanged. A dime edge during CHANGE -> coin_reject and the refund count is unaffected.
- Quarter held high across rst_n deassertion -> no credit. Release then press -> credit=5. Assert rst_n mid-CHANGE -> credit=0 and all pulses 0 immediately.

Source files
------------

// File: rtl/coin_credit_if.sv
// Coin/button inputs and credit/pulse outputs of the vending credit stage.
// The master drives the synchronised inputs; the slave is the credit FSM.
interface coin_credit_if;
  logic       coin_nickel;
  logic       coin_dime;
  logic       coin_quarter;
  logic       vend_req;
  logic       cancel;
  logic [3:0] credit;
  logic       dispense;
  logic       change_nickel;
  logic       coin_reject;
  logic       vend_denied;
  logic       busy;

  modport master (
    output coin_nickel, coin_dime, coin_quarter, vend_req, cancel,
    input  credit, dispense, change_nickel, coin_reject, vend_denied, busy
  );

  modport slave (
    input  coin_nickel, coin_dime, coin_quarter, vend_req, cancel,
    output credit, dispense, change_nickel, coin_reject, vend_denied, busy
  );
endinterface

// File: rtl/coin_credit_fsm.sv
// Credit keeper for the vending machine: accepts coins, vends at PRICE and
// pays change one nickel per cycle. credit is in nickels and feeds the digit decoders.
module coin_credit_fsm #(
  parameter int unsigned MAX_CREDIT = 12,
  parameter int unsigned PRICE      = 7
) (
  input logic          clk,
  input logic          rst_n,
  coin_credit_if.slave bus
);
  typedef enum logic [1:0] {ACCEPT, VEND, CHANGE} state_t;

  localparam logic [4:0] MAX_CREDIT_W = 5'(MAX_CREDIT);
  localparam logic [3:0] PRICE_W      = 4'(PRICE);

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       dispense_q, dispense_d;
  logic       change_q, change_d;
  logic       reject_q, reject_d;
  logic       denied_q, denied_d;
  logic       busy_q, busy_d;

  // Bit order: cancel, vend_req, quarter, dime, nickel.
  logic [4:0] in_now, prev_q, edge_w;
  logic [1:0] coin_cnt;
  logic       any_coin;
  logic [4:0] coin_val;
  logic [4:0] sum;

  assign in_now   = {bus.cancel, bus.vend_req, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
  assign edge_w   = in_now & ~prev_q;
  assign coin_cnt = {1'b0, edge_w[0]} + {1'b0, edge_w[1]} + {1'b0, edge_w[2]};
  assign any_coin = |edge_w[2:0];

  always_comb begin
    coin_val = 5'd0;
    if (edge_w[0]) coin_val = 5'd1;
    else if (edge_w[1]) coin_val = 5'd2;
    else if (edge_w[2]) coin_val = 5'd5;
  end

  // 5-bit sum so an overflowing coin can be detected before it is committed.
  assign sum = {1'b0, credit_q} + coin_val;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    denied_d   = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        if (edge_w[4]) begin
          if (credit_q != 4'd0) state_d = CHANGE;
          reject_d = any_coin;
        end else if (edge_w[3] && credit_q >= PRICE_W) begin
          credit_d   = credit_q - PRICE_W;
          dispense_d = 1'b1;
          state_d    = VEND;
          reject_d   = any_coin;
        end else begin
          denied_d = edge_w[3];
          if (coin_cnt == 2'd1) begin
            if (sum <= MAX_CREDIT_W) credit_d = sum[3:0];
            else                     reject_d = 1'b1;
          end else if (coin_cnt >= 2'd2) begin
            reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        reject_d = any_coin;
        state_d  = (credit_q != 4'd0) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        reject_d = any_coin;
        if (credit_q != 4'd0) begin
          credit_d = credit_q - 4'd1;
          change_d = 1'b1;
        end
        if (credit_q <= 4'd1) state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
    busy_d = (state_d != ACCEPT);
  end

  // History resets high so a level held through reset is not seen as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCEPT;
      credit_q   <= 4'd0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      denied_q   <= 1'b0;
      busy_q     <= 1'b0;
      prev_q     <= 5'b11111;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      denied_q   <= denied_d;
      busy_q     <= busy_d;
      prev_q     <= in_now;
    end
  end

  assign bus.credit        = credit_q;
  assign bus.dispense      = dispense_q;
  assign bus.change_nickel = change_q;
  assign bus.coin_reject   = reject_q;
  assign bus.vend_denied   = denied_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_coin_credit_fsm.sv
// Scoreboard bench for coin_credit_fsm: each stimulus cycle pushes the
// expected post-edge outputs; a monitor pops and compares after every edge.
module tb_coin_credit_fsm;
  typedef struct packed {
    logic [4:0] stim;
    logic [3:0] credit;
    logic       disp;
    logic       chg;
    logic       rej;
    logic       den;
    logic       busy;
  } exp_t;

  localparam logic [4:0] I0 = 5'b00000;
  localparam logic [4:0] IN = 5'b00001;
  localparam logic [4:0] ID = 5'b00010;
  localparam logic [4:0] IQ = 5'b00100;
  localparam logic [4:0] IV = 5'b01000;
  localparam logic [4:0] IC = 5'b10000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  coin_credit_if bus_if ();

  coin_credit_fsm #(.MAX_CREDIT(12), .PRICE(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {bus_if.cancel, bus_if.vend_req, bus_if.coin_quarter, bus_if.coin_dime, bus_if.coin_nickel} = in;
  endtask

  task automatic step(input logic [4:0] in, input logic [3:0] c, input logic d,
                      input logic ch, input logic rj, input logic dn, input logic b);
    exp_t e;
    @(negedge clk);
    drive(in);
    e = '{stim: in, credit: c, disp: d, chg: ch, rej: rj, den: dn, busy: b};
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_credit"}, int'(bus_if.credit), 0);
    check_val({tag, "_dispense"}, int'(bus_if.dispense), 0);
    check_val({tag, "_change"}, int'(bus_if.change_nickel), 0);
    check_val({tag, "_reject"}, int'(bus_if.coin_reject), 0);
    check_val({tag, "_denied"}, int'(bus_if.vend_denied), 0);
    check_val({tag, "_busy"}, int'(bus_if.busy), 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("t=%0t in=%b credit=%0d disp=%b chg=%b rej=%b den=%b busy=%b",
               $time, e.stim, bus_if.credit, bus_if.dispense, bus_if.change_nickel,
               bus_if.coin_reject, bus_if.vend_denied, bus_if.busy);
      check_val("credit", int'(bus_if.credit), int'(e.credit));
      check_val("dispense", int'(bus_if.dispense), int'(e.disp));
      check_val("change_nickel", int'(bus_if.change_nickel), int'(e.chg));
      check_val("coin_reject", int'(bus_if.coin_reject), int'(e.rej));
      check_val("vend_denied", int'(bus_if.vend_denied), int'(e.den));
      check_val("busy", int'(bus_if.busy), int'(e.busy));
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(I0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Coins accumulate: quarter, dime, nickel -> 5, 7, 8.
    step(I0, 0, 0, 0, 0, 0, 0);
    step(IQ, 5, 0, 0, 0, 0, 0);
    step(I0, 5, 0, 0, 0, 0, 0);
    step(ID, 7, 0, 0, 0, 0, 0);
    step(I0, 7, 0, 0, 0, 0, 0);
    step(IN, 8, 0, 0, 0, 0, 0);
    step(I0, 8, 0, 0, 0, 0, 0);

    // Vend at 8: one nickel change.
    step(IV, 1, 1, 0, 0, 0, 1);
    step(I0, 1, 0, 0, 0, 0, 1);
    step(I0, 0, 0, 1, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);

    // Overflow rejection and exact fill to MAX_CREDIT.
    step(IQ, 5, 0, 0, 0, 0, 0);
    step(I0, 5, 0, 0, 0, 0, 0);
    step(IQ, 10, 0, 0, 0, 0, 0);
    step(I0, 10, 0, 0, 0, 0, 0);
    step(IQ, 10, 0, 0, 1, 0, 0);
    step(I0, 10, 0, 0, 0, 0, 0);
    step(ID, 12, 0, 0, 0, 0, 0);
    step(I0, 12, 0, 0, 0, 0, 0);
    step(IN, 12, 0, 0, 1, 0, 0);
    step(I0, 12, 0, 0, 0, 0, 0);

    // Vend at 12: five nickels of change.
    step(IV, 5, 1, 0, 0, 0, 1);
    step(I0, 5, 0, 0, 0, 0, 1);
    step(I0, 4, 0, 1, 0, 0, 1);
    step(I0, 3, 0, 1, 0, 0, 1);
    step(I0, 2, 0, 1, 0, 0, 1);
    step(I0, 1, 0, 1, 0, 0, 1);
    step(I0, 0, 0, 1, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);

    // Credit 3: vend denied, then cancel refunds three nickels.
    step(ID, 2, 0, 0, 0, 0, 0);
    step(I0, 2, 0, 0, 0, 0, 0);
    step(IN, 3, 0, 0, 0, 0, 0);
    step(I0, 3, 0, 0, 0, 0, 0);
    step(IV, 3, 0, 0, 0, 1, 0);
    step(I0, 3, 0, 0, 0, 0, 0);
    step(IC, 3, 0, 0, 0, 0, 1);
    step(I0, 2, 0, 1, 0, 0, 1);
    step(I0, 1, 0, 1, 0, 0, 1);
    step(I0, 0, 0, 1, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);
    step(IC, 0, 0, 0, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);

    // Simultaneous coins rejected; coin during CHANGE rejected.
    step(IN | ID, 0, 0, 0, 1, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);
    step(ID, 2, 0, 0, 0, 0, 0);
    step(I0, 2, 0, 0, 0, 0, 0);
    step(IC, 2, 0, 0, 0, 0, 1);
    step(ID | IV, 1, 0, 1, 1, 0, 1);
    step(I0, 0, 0, 1, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);

    // Denied vend still takes a coin; cancel rejects a coin.
    step(IV | IN, 1, 0, 0, 0, 1, 0);
    step(I0, 1, 0, 0, 0, 0, 0);
    step(IC | ID, 1, 0, 0, 1, 0, 1);
    step(I0, 0, 0, 1, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);

    // Reset mid-CHANGE, with quarter held across reset release.
    step(IQ, 5, 0, 0, 0, 0, 0);
    step(I0, 5, 0, 0, 0, 0, 0);
    step(IC, 5, 0, 0, 0, 0, 1);
    step(I0, 4, 0, 1, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(IQ);
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(IQ, 0, 0, 0, 0, 0, 0);
    step(IQ, 0, 0, 0, 0, 0, 0);
    step(I0, 0, 0, 0, 0, 0, 0);
    step(IQ, 5, 0, 0, 0, 0, 0);
    step(I0, 5, 0, 0, 0, 0, 0);

    check_val("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
